// File: rtl/keys_pkg.sv
// keys_pkg: shared key channel state encoding and default timing constants.
package keys_pkg;
  typedef enum logic [1:0] {KEY_IDLE, KEY_PRESS_DB, KEY_HELD, KEY_RELEASE_DB} key_st_e;
  localparam int CLK_PER_MS_50M = 50000;
  localparam int DEBOUNCE_MS_DEF = 20;
endpackage

// File: rtl/key_channel.sv
// key_channel: one key's synchroniser, debounce FSM, hold/repeat counters and registered events.
module key_channel
  import keys_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
  parameter int LONG_MS = 1000,
  parameter int REPEAT_MS = 200,
  parameter int ACTIVE_LOW = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic tick,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_repeat
);
  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam int HW = $clog2(LONG_MS + 1);
  localparam int RW = REPEAT_MS > 0 ? $clog2(REPEAT_MS + 1) : 1;
  localparam logic REL = ACTIVE_LOW != 0;
  logic [1:0] sync;
  logic p;
  key_st_e st;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;
  assign p = sync[1] ^ REL;
  always_ff @(posedge CLK or posedge RST)
    if (RST) sync <= {2{REL}};
    else sync <= {sync[0], key_in};
  // A p change always beats a coincident tick: the tick is simply not counted.
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      st <= KEY_IDLE;
      db_cnt <= '0;
      hold_cnt <= '0;
      rep_cnt <= '0;
      key_state <= 1'b0;
      key_press <= 1'b0;
      key_release <= 1'b0;
      key_long <= 1'b0;
      key_repeat <= 1'b0;
    end else begin
      key_press <= 1'b0;
      key_release <= 1'b0;
      key_long <= 1'b0;
      key_repeat <= 1'b0;
      case (st)
        KEY_IDLE:
          if (p) begin
            st <= KEY_PRESS_DB;
            db_cnt <= '0;
          end
        KEY_PRESS_DB:
          if (!p) st <= KEY_IDLE;
          else if (tick) begin
            if (db_cnt == DW'(DEBOUNCE_MS - 1)) begin
              st <= KEY_HELD;
              key_press <= 1'b1;
              key_state <= 1'b1;
              hold_cnt <= '0;
              rep_cnt <= '0;
            end else db_cnt <= db_cnt + 1'b1;
          end
        KEY_HELD:
          if (!p) begin
            st <= KEY_RELEASE_DB;
            db_cnt <= '0;
          end else if (tick) begin
            if (hold_cnt != HW'(LONG_MS)) begin
              hold_cnt <= hold_cnt + 1'b1;
              key_long <= hold_cnt == HW'(LONG_MS - 1);
            end else if (REPEAT_MS > 0) begin
              key_repeat <= rep_cnt == RW'(REPEAT_MS - 1);
              rep_cnt <= rep_cnt == RW'(REPEAT_MS - 1) ? '0 : rep_cnt + 1'b1;
            end
          end
        KEY_RELEASE_DB:
          if (p) st <= KEY_HELD;
          else if (tick) begin
            if (db_cnt == DW'(DEBOUNCE_MS - 1)) begin
              st <= KEY_IDLE;
              key_release <= 1'b1;
              key_state <= 1'b0;
            end else db_cnt <= db_cnt + 1'b1;
          end
        default: st <= KEY_IDLE;
      endcase
    end
endmodule

// File: rtl/keys_debounce_multi.sv
// keys_debounce_multi: shared 1 ms tick generator feeding N independent key channels.
module keys_debounce_multi
  import keys_pkg::*;
#(
  parameter int N_KEYS = 4,
  parameter int CLK_PER_MS = CLK_PER_MS_50M,
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
  parameter int LONG_MS = 1000,
  parameter int REPEAT_MS = 200,
  parameter int ACTIVE_LOW = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat
);
  localparam int TW = CLK_PER_MS > 1 ? $clog2(CLK_PER_MS) : 1;
  logic [TW-1:0] tick_cnt;
  logic tick;
  assign tick = tick_cnt == TW'(CLK_PER_MS - 1);
  always_ff @(posedge CLK or posedge RST)
    if (RST) tick_cnt <= '0;
    else tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel #(
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .LONG_MS(LONG_MS),
      .REPEAT_MS(REPEAT_MS),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .CLK(CLK),
      .RST(RST),
      .tick(tick),
      .key_in(key_in[i]),
      .key_state(key_state[i]),
      .key_press(key_press[i]),
      .key_release(key_release[i]),
      .key_long(key_long[i]),
      .key_repeat(key_repeat[i])
    );
  end
endmodule

// File: tb/tb_keys_debounce_multi.sv
// tb_keys_debounce_multi: directed debounce/long/repeat/reset scenarios with hand-computed event cycles.
module tb_keys_debounce_multi;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [1:0] key_in = 2'b11;
  logic [1:0] key_state, key_press, key_release, key_long, key_repeat;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int n_press[2] = '{0, 0};
  int n_rel[2] = '{0, 0};
  int n_long[2] = '{0, 0};
  int n_rep[2] = '{0, 0};
  int last_press[2] = '{-1, -1};
  int last_rel[2] = '{-1, -1};
  int last_long[2] = '{-1, -1};
  int first_rep[2] = '{-1, -1};
  int last_rep[2] = '{-1, -1};
  int both_cyc = -1;
  int bad_state = 0;
  int np0, np1, nr0, nr1;

  keys_debounce_multi #(
    .N_KEYS(2), .CLK_PER_MS(10), .DEBOUNCE_MS(3), .LONG_MS(10), .REPEAT_MS(4), .ACTIVE_LOW(1)
  ) dut (
    .CLK(CLK), .RST(RST), .key_in(key_in), .key_state(key_state), .key_press(key_press),
    .key_release(key_release), .key_long(key_long), .key_repeat(key_repeat)
  );

  always #5 CLK = ~CLK;

  // cyc = rising edges since reset release; ticks are counted on edges where cyc % 10 == 0
  always @(posedge CLK or posedge RST)
    if (RST) cyc <= 0;
    else cyc <= cyc + 1;

  always @(negedge CLK)
    for (int i = 0; i < 2; i++) begin
      if (key_press[i]) begin
        n_press[i]++;
        last_press[i] = cyc;
        if (!key_state[i]) bad_state++;
      end
      if (key_release[i]) begin
        n_rel[i]++;
        last_rel[i] = cyc;
        if (key_state[i]) bad_state++;
      end
      if (key_long[i]) begin
        n_long[i]++;
        last_long[i] = cyc;
      end
      if (key_repeat[i]) begin
        if (n_rep[i] == 0) first_rep[i] = cyc;
        n_rep[i]++;
        last_rep[i] = cyc;
      end
      if (key_press == 2'b11) both_cyc = cyc;
    end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc < n && g < 5000) begin
      @(posedge CLK);
      #1;
      g++;
    end
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check("reset_outputs", {key_state, key_press, key_release, key_long, key_repeat}, 0);
    @(negedge CLK);
    RST = 1'b0;
    // clean press on ch0, then clean release
    wait_cyc(5);   key_in[0] = 1'b0;
    wait_cyc(55);  key_in[0] = 1'b1;
    wait_cyc(90);
    check("clean_press_count", n_press[0], 1);
    check("clean_press_cyc", last_press[0], 30);
    check("clean_release_cyc", last_rel[0], 80);
    check("clean_state_low", key_state[0], 0);
    check("ch1_idle", n_press[1] + n_rel[1] + n_long[1] + n_rep[1], 0);
    // press bounce: low 15, high 5, low steady
    wait_cyc(100); key_in[0] = 1'b0;
    wait_cyc(115); key_in[0] = 1'b1;
    wait_cyc(120); key_in[0] = 1'b0;
    wait_cyc(160);
    check("bounce_press_count", n_press[0], 2);
    check("bounce_press_cyc", last_press[0], 150);
    check("bounce_state_high", key_state[0], 1);
    // release bounce that returns to held: hold count must freeze, so long lands at 270 not 250
    wait_cyc(175); key_in[0] = 1'b1;
    wait_cyc(187); key_in[0] = 1'b0;
    wait_cyc(280);
    check("held_bounce_no_release", n_rel[0], 1);
    check("long_ch0_count", n_long[0], 1);
    check("long_ch0_cyc", last_long[0], 270);
    // release with bounce: high 12, low 4, high steady
    wait_cyc(285); key_in[0] = 1'b1;
    wait_cyc(297); key_in[0] = 1'b0;
    wait_cyc(301); key_in[0] = 1'b1;
    wait_cyc(340);
    check("bounce_release_count", n_rel[0], 2);
    check("bounce_release_cyc", last_rel[0], 330);
    check("ch0_no_repeat", n_rep[0], 0);
    // long hold on ch1 for 200 ticks
    wait_cyc(400);  key_in[1] = 1'b0;
    wait_cyc(2400); key_in[1] = 1'b1;
    wait_cyc(2440);
    check("ch1_press_count", n_press[1], 1);
    check("ch1_press_cyc", last_press[1], 430);
    check("ch1_long_count", n_long[1], 1);
    check("ch1_long_cyc", last_long[1], 530);
    check("ch1_repeat_count", n_rep[1], 46);
    check("ch1_first_repeat", first_rep[1], 570);
    check("ch1_last_repeat", last_rep[1], 2370);
    check("ch1_release_cyc", last_rel[1], 2430);
    // simultaneous press
    wait_cyc(2500); key_in = 2'b00;
    wait_cyc(2540);
    check("both_press_cyc", both_cyc, 2530);
    check("both_state", key_state, 2'b11);
    // reset while key_long pulses on both channels
    wait_cyc(2630);
    check("both_long_pre_reset", key_long, 2'b11);
    np0 = n_press[0];
    np1 = n_press[1];
    nr0 = n_rel[0];
    nr1 = n_rel[1];
    RST = 1'b1;
    #1;
    check("async_reset_outputs", {key_state, key_press, key_release, key_long, key_repeat}, 0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    wait_cyc(40);
    check("post_reset_press0", n_press[0] - np0, 1);
    check("post_reset_press1", n_press[1] - np1, 1);
    check("post_reset_press_cyc", last_press[0], 30);
    check("post_reset_no_release", (n_rel[0] - nr0) + (n_rel[1] - nr1), 0);
    check("post_reset_state", key_state, 2'b11);
    check("pulse_state_consistency", bad_state, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
